sample_block_packer: RTL and testbench

Upstream feeder for dual-port 3D block RAM. Accepts a serial stream of NB_DATA-bit samples over a valid/ready handshake and packs NP consecutive samples into one block. Each full block is written to the next free RAM block slot, which forms a P-deep circular block buffer. The block publishes the oldest full slot to the downstream consumer and applies back-pressure when all P slots are occupied.

---
 rtl/sample_block_packer_if.sv | 34 +++
 rtl/sample_block_packer.sv | 123 ++++++++++++
 tb/tb_sample_block_packer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_block_packer_if.sv
// Sample-stream and block-RAM signal bundle for sample_block_packer.
// The packer uses the slave modport; its environment uses master.
interface sample_block_packer_if #(
  parameter int P       = 2,
  parameter int NP      = 1024,
  parameter int NB_DATA = 32
);
  localparam int AW = $clog2(P);
  localparam int FW = $clog2(P + 1);

  logic                         i_valid;
  logic [NB_DATA-1:0]           i_sample;
  logic                         o_ready;
  logic                         o_enable;
  logic                         o_wenable;
  logic [AW-1:0]                o_write_addr;
  logic [NP-1:0][NB_DATA-1:0]   o_data;
  logic [AW-1:0]                o_read_addr;
  logic                         o_block_valid;
  logic                         i_block_release;
  logic [FW-1:0]                o_fill_count;

  modport slave (
    input  i_valid, i_sample, i_block_release,
    output o_ready, o_enable, o_wenable, o_write_addr, o_data,
           o_read_addr, o_block_valid, o_fill_count
  );

  modport master (
    output i_valid, i_sample, i_block_release,
    input  o_ready, o_enable, o_wenable, o_write_addr, o_data,
           o_read_addr, o_block_valid, o_fill_count
  );
endinterface

// File: rtl/sample_block_packer.sv
// Packs NP serial samples into one block and commits it to a P-slot circular RAM buffer.
// state  | meaning
// FILL   | accepting samples into the packing register
// WAIT   | block complete, all slots full, holding until a release
// COMMIT | one-cycle RAM write of the packed block to wr_ptr
module sample_block_packer #(
  parameter int P       = 2,
  parameter int NP      = 1024,
  parameter int NB_DATA = 32
) (
  input  logic clock,
  input  logic i_reset_n,
  sample_block_packer_if.slave bus
);
  localparam int AW = $clog2(P);
  localparam int CW = $clog2(NP);
  localparam int FW = $clog2(P + 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [FW-1:0]              r_fill;
  logic [NP-1:0][NB_DATA-1:0] r_data;
  logic                       r_ready;
  logic                       r_enable;
  logic                       r_wenable;
  logic [AW-1:0]              r_write_addr;
  logic                       r_block_valid;

  state_t        w_state_next;
  logic          w_accept;
  logic          w_last;
  logic          w_release;
  logic          w_commit;
  logic [FW-1:0] w_fill_rel;
  logic [FW-1:0] w_fill_new;
  logic [AW-1:0] w_wr_ptr_inc;
  logic [AW-1:0] w_rd_ptr_inc;

  assign w_accept  = bus.i_valid && r_ready;
  assign w_last    = (r_cnt == CW'(NP - 1));
  assign w_release = bus.i_block_release && (r_fill != '0);
  assign w_commit  = (r_state == S_COMMIT);

  // fill after this cycle's release decides whether a finished block may commit
  assign w_fill_rel = w_release ? (r_fill - FW'(1)) : r_fill;
  assign w_fill_new = w_commit ? (w_fill_rel + FW'(1)) : w_fill_rel;

  // explicit wrap so non power-of-two P works
  assign w_wr_ptr_inc = (r_wr_ptr == AW'(P - 1)) ? '0 : (r_wr_ptr + AW'(1));
  assign w_rd_ptr_inc = (r_rd_ptr == AW'(P - 1)) ? '0 : (r_rd_ptr + AW'(1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept && w_last) begin
          w_state_next = (w_fill_rel < FW'(P)) ? S_COMMIT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_release) begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: w_state_next = S_FILL;
      default:  w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_FILL;
      r_cnt         <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fill        <= '0;
      r_data        <= '0;
      r_ready       <= 1'b0;
      r_enable      <= 1'b0;
      r_wenable     <= 1'b0;
      r_write_addr  <= '0;
      r_block_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_enable      <= 1'b1;
      r_ready       <= (w_state_next == S_FILL);
      r_wenable     <= (w_state_next == S_COMMIT);
      r_write_addr  <= (w_state_next == S_COMMIT) ? r_wr_ptr : '0;
      r_fill        <= w_fill_new;
      r_block_valid <= (w_fill_new != '0);

      if (w_accept) begin
        r_data[r_cnt] <= bus.i_sample;
        r_cnt         <= w_last ? '0 : (r_cnt + CW'(1));
      end

      if (w_commit) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end

      if (w_release) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
    end
  end

  assign bus.o_ready       = r_ready;
  assign bus.o_enable      = r_enable;
  assign bus.o_wenable     = r_wenable;
  assign bus.o_write_addr  = r_write_addr;
  assign bus.o_data        = r_data;
  assign bus.o_read_addr   = r_rd_ptr;
  assign bus.o_block_valid = r_block_valid;
  assign bus.o_fill_count  = r_fill;
endmodule

// File: tb/tb_sample_block_packer.sv
// Directed bench for sample_block_packer with P=2, NP=4, NB_DATA=8.
module tb_sample_block_packer;
  localparam int P  = 2;
  localparam int NP = 4;
  localparam int NB = 8;

  logic clock;
  logic i_reset_n;
  int   n_pass;
  int   n_total;

  sample_block_packer_if #(.P(P), .NP(NP), .NB_DATA(NB)) bus ();

  sample_block_packer #(.P(P), .NP(NP), .NB_DATA(NB)) dut (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] blk(input int b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) r[i*NB +: NB] = 8'(b + i);
    return r;
  endfunction

  // holds valid high until n samples starting at first have been accepted
  task automatic feed(input int first, input int n);
    int k;
    int cyc;
    logic acc;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 100) begin
      bus.i_valid  = 1'b1;
      bus.i_sample = 8'(first + k);
      acc = bus.o_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    bus.i_valid = 1'b0;
    chk("feed_accepts", 32'(k), 32'(n));
  endtask

  task automatic do_reset();
    #2 i_reset_n = 1'b0;
    #2 i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int commits;
    int next_s;
    int cyc;
    logic v;
    logic acc;

    n_pass = 0;
    n_total = 0;
    clock = 1'b0;
    i_reset_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_sample = '0;
    bus.i_block_release = 1'b0;

    #12;
    chk("rst_ready",  32'(bus.o_ready), 32'd0);
    chk("rst_enable", 32'(bus.o_enable), 32'd0);
    chk("rst_fill",   32'(bus.o_fill_count), 32'd0);
    chk("rst_data",   bus.o_data, 32'd0);
    i_reset_n = 1'b1;
    tick();
    chk("enable_after_rst", 32'(bus.o_enable), 32'd1);
    chk("ready_after_rst",  32'(bus.o_ready), 32'd1);

    // release with nothing buffered is ignored
    bus.i_block_release = 1'b1;
    tick();
    bus.i_block_release = 1'b0;
    chk("empty_rel_fill",  32'(bus.o_fill_count), 32'd0);
    chk("empty_rel_raddr", 32'(bus.o_read_addr), 32'd0);
    chk("empty_rel_bv",    32'(bus.o_block_valid), 32'd0);

    // first block
    feed(1, 4);
    chk("t1_wen",   32'(bus.o_wenable), 32'd1);
    chk("t1_waddr", 32'(bus.o_write_addr), 32'd0);
    chk("t1_data",  bus.o_data, 32'h04030201);
    chk("t1_ready", 32'(bus.o_ready), 32'd0);
    tick();
    chk("t1_fill",  32'(bus.o_fill_count), 32'd1);
    chk("t1_bv",    32'(bus.o_block_valid), 32'd1);
    chk("t1_raddr", 32'(bus.o_read_addr), 32'd0);
    chk("t1_wen_off", 32'(bus.o_wenable), 32'd0);
    chk("t1_ready_back", 32'(bus.o_ready), 32'd1);

    // release during commit: fill unchanged, both pointers advance
    feed(5, 4);
    chk("t3_waddr", 32'(bus.o_write_addr), 32'd1);
    bus.i_block_release = 1'b1;
    tick();
    bus.i_block_release = 1'b0;
    chk("t3_fill",  32'(bus.o_fill_count), 32'd1);
    chk("t3_raddr", 32'(bus.o_read_addr), 32'd1);
    feed(8'h11, 4);
    chk("t3_waddr_wrap", 32'(bus.o_write_addr), 32'd0);
    bus.i_block_release = 1'b1;
    tick();
    bus.i_block_release = 1'b0;
    chk("t3_fill2",  32'(bus.o_fill_count), 32'd1);
    chk("t3_raddr_wrap", 32'(bus.o_read_addr), 32'd0);

    // async reset mid-block with fill=1
    feed(8'hAA, 2);
    chk("t6_fill_pre", 32'(bus.o_fill_count), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("t6_ready", 32'(bus.o_ready), 32'd0);
    chk("t6_enable", 32'(bus.o_enable), 32'd0);
    chk("t6_fill", 32'(bus.o_fill_count), 32'd0);
    chk("t6_bv", 32'(bus.o_block_valid), 32'd0);
    chk("t6_data", bus.o_data, 32'd0);
    #2 i_reset_n = 1'b1;
    tick();
    feed(7, 4);
    chk("t6_wen",   32'(bus.o_wenable), 32'd1);
    chk("t6_waddr", 32'(bus.o_write_addr), 32'd0);
    chk("t6_data_blk", bus.o_data, 32'h0A090807);
    tick();
    chk("t6_fill_post", 32'(bus.o_fill_count), 32'd1);

    // fill both slots, third block stalls in WAIT
    do_reset();
    feed(1, 4);
    chk("t2_waddr0", 32'(bus.o_write_addr), 32'd0);
    feed(5, 4);
    chk("t2_waddr1", 32'(bus.o_write_addr), 32'd1);
    feed(9, 4);
    chk("t2_wait_ready", 32'(bus.o_ready), 32'd0);
    chk("t2_wait_wen",   32'(bus.o_wenable), 32'd0);
    chk("t2_wait_fill",  32'(bus.o_fill_count), 32'd2);
    chk("t2_wait_data",  bus.o_data, 32'h0C0B0A09);
    bus.i_valid = 1'b1;
    bus.i_sample = 8'hEE;
    tick();
    bus.i_valid = 1'b0;
    chk("t2_hold_data", bus.o_data, 32'h0C0B0A09);
    chk("t2_hold_ready", 32'(bus.o_ready), 32'd0);
    bus.i_block_release = 1'b1;
    tick();
    bus.i_block_release = 1'b0;
    chk("t2_commit_wen",   32'(bus.o_wenable), 32'd1);
    chk("t2_commit_waddr", 32'(bus.o_write_addr), 32'd0);
    chk("t2_commit_data",  bus.o_data, 32'h0C0B0A09);
    chk("t2_commit_raddr", 32'(bus.o_read_addr), 32'd1);
    chk("t2_commit_fill",  32'(bus.o_fill_count), 32'd1);
    tick();
    chk("t2_final_fill", 32'(bus.o_fill_count), 32'd2);
    chk("t2_final_raddr", 32'(bus.o_read_addr), 32'd1);

    // randomly gapped ramp 0..11 across three blocks
    do_reset();
    commits = 0;
    next_s = 0;
    cyc = 0;
    while (commits < 3 && cyc < 300) begin
      v = 1'($urandom_range(0, 1));
      bus.i_valid = v && (next_s < 12);
      bus.i_sample = 8'(next_s);
      bus.i_block_release = (bus.o_fill_count == 2'd2) ||
                            (bus.o_block_valid && ($urandom_range(0, 2) == 0));
      acc = bus.i_valid && bus.o_ready;
      tick();
      if (acc) next_s++;
      if (bus.o_wenable) begin
        chk("ramp_data",  bus.o_data, blk(commits * NP));
        chk("ramp_waddr", 32'(bus.o_write_addr), 32'(commits % P));
        commits++;
      end
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_block_release = 1'b0;
    chk("ramp_commits", 32'(commits), 32'd3);
    chk("ramp_accepts", 32'(next_s), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
